// File: rtl/osd_regaccess_arb_if.sv
// Bus bundle between NUM_REQ register-access requesters, the arbiter and one shared target port.
// The slave modport is the arbiter's view. The master modport is the surrounding system: requesters plus target.
interface osd_regaccess_arb_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_request;
  logic [NUM_REQ-1:0]    req_write;
  logic [16*NUM_REQ-1:0] req_addr;
  logic [NUM_REQ-1:0]    req_size;
  logic [16*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ack;
  logic [NUM_REQ-1:0]    req_err;
  logic [15:0]           req_rdata;

  logic                  reg_request;
  logic                  reg_write;
  logic [15:0]           reg_addr;
  logic                  reg_size;
  logic [15:0]           reg_wdata;
  logic                  reg_ack;
  logic                  reg_err;
  logic [15:0]           reg_rdata;

  logic                  timeout;

  modport slave (
    input  req_request, req_write, req_addr, req_size, req_wdata,
    input  reg_ack, reg_err, reg_rdata,
    output req_ack, req_err, req_rdata,
    output reg_request, reg_write, reg_addr, reg_size, reg_wdata,
    output timeout
  );

  modport master (
    output req_request, req_write, req_addr, req_size, req_wdata,
    output reg_ack, reg_err, reg_rdata,
    input  req_ack, req_err, req_rdata,
    input  reg_request, reg_write, reg_addr, reg_size, reg_wdata,
    input  timeout
  );
endinterface

// File: rtl/osd_regaccess_arb.sv
// Round-robin arbiter that serialises NUM_REQ requesters onto one module register-access port.
// Define OSD_REGARB_TIMEOUT_EN to retire accesses stuck in ACCESS for TIMEOUT cycles with an error.
module osd_regaccess_arb #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  osd_regaccess_arb_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [IDX_W-1:0]   grant_reg;
  logic               reg_request_reg;
  logic               reg_write_reg;
  logic               reg_size_reg;
  logic [15:0]        reg_addr_reg;
  logic [15:0]        reg_wdata_reg;
  logic [NUM_REQ-1:0] req_ack_reg;
  logic [NUM_REQ-1:0] req_err_reg;
  logic [15:0]        req_rdata_reg;

  logic [15:0]        addr_arr  [NUM_REQ];
  logic [15:0]        wdata_arr [NUM_REQ];
  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] req_rot;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_off;
  logic [IDX_W:0]     pick_sum;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   ptr_next;
  logic               done;
  logic               tmo_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_arr[gi]  = bus.req_addr[16*gi +: 16];
      assign wdata_arr[gi] = bus.req_wdata[16*gi +: 16];
      assign grant_oh[gi]  = (grant_reg == IDX_W'(gi));
    end
  endgenerate

  // Rotate requests so bit 0 is the requester at rr_ptr; the lowest set bit is then the winner.
  assign req_rot = NUM_REQ'({bus.req_request, bus.req_request} >> rr_ptr_reg);

  always_comb begin
    pick_valid = 1'b0;
    pick_off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_valid = 1'b1;
        pick_off   = IDX_W'(k);
      end
    end
  end

  assign pick_sum = {1'b0, rr_ptr_reg} + {1'b0, pick_off};
  assign pick_idx = (pick_sum >= (IDX_W+1)'(NUM_REQ))
                    ? IDX_W'(pick_sum - (IDX_W+1)'(NUM_REQ))
                    : pick_sum[IDX_W-1:0];

  assign ptr_next = (grant_reg == IDX_W'(NUM_REQ - 1)) ? '0 : grant_reg + IDX_W'(1);
  assign done     = bus.reg_ack | bus.reg_err;

`ifdef OSD_REGARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_reg;
  logic        timeout_reg;

  // A completion in the expiry cycle wins over the timeout.
  assign tmo_hit     = ~done & (tmo_cnt_reg == 16'(TIMEOUT - 1));
  assign bus.timeout = timeout_reg;
`else
  logic unused_timeout_param;

  assign unused_timeout_param = (TIMEOUT == 0);
  assign tmo_hit              = 1'b0;
  assign bus.timeout          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      grant_reg       <= '0;
      reg_request_reg <= 1'b0;
      reg_write_reg   <= 1'b0;
      reg_size_reg    <= 1'b0;
      reg_addr_reg    <= '0;
      reg_wdata_reg   <= '0;
      req_ack_reg     <= '0;
      req_err_reg     <= '0;
      req_rdata_reg   <= '0;
`ifdef OSD_REGARB_TIMEOUT_EN
      tmo_cnt_reg     <= '0;
      timeout_reg     <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            grant_reg       <= pick_idx;
            reg_write_reg   <= bus.req_write[pick_idx];
            reg_size_reg    <= bus.req_size[pick_idx];
            reg_addr_reg    <= addr_arr[pick_idx];
            reg_wdata_reg   <= wdata_arr[pick_idx];
            reg_request_reg <= 1'b1;
`ifdef OSD_REGARB_TIMEOUT_EN
            tmo_cnt_reg     <= '0;
`endif
            state_reg       <= ACCESS;
          end
        end

        ACCESS: begin
          if (done || tmo_hit) begin
            reg_request_reg <= 1'b0;
            req_ack_reg     <= grant_oh;
            // reg_err flags an error even when reg_ack accompanies it.
            req_err_reg     <= (bus.reg_err || tmo_hit) ? grant_oh : '0;
            // Writes leave the shared read-data register untouched, timeout included.
            if (!reg_write_reg) begin
              req_rdata_reg <= done ? bus.reg_rdata : 16'h0000;
            end
`ifdef OSD_REGARB_TIMEOUT_EN
            timeout_reg     <= tmo_hit;
`endif
            state_reg       <= RESP;
          end
`ifdef OSD_REGARB_TIMEOUT_EN
          else begin
            tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
          end
`endif
        end

        RESP: begin
          req_ack_reg <= '0;
          req_err_reg <= '0;
          rr_ptr_reg  <= ptr_next;
`ifdef OSD_REGARB_TIMEOUT_EN
          timeout_reg <= 1'b0;
`endif
          state_reg   <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req_ack     = req_ack_reg;
  assign bus.req_err     = req_err_reg;
  assign bus.req_rdata   = req_rdata_reg;
  assign bus.reg_request = reg_request_reg;
  assign bus.reg_write   = reg_write_reg;
  assign bus.reg_size    = reg_size_reg;
  assign bus.reg_addr    = reg_addr_reg;
  assign bus.reg_wdata   = reg_wdata_reg;

endmodule

// File: tb/tb_osd_regaccess_arb.sv
// Directed bench for osd_regaccess_arb with a behavioural target and an expected-completion scoreboard.
// Expected results are queued at stimulus time and compared when the arbiter pulses req_ack.
module tb_osd_regaccess_arb;

  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  osd_regaccess_arb_if #(.NUM_REQ(NUM_REQ)) bus ();

  osd_regaccess_arb #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Target: acks tgt_delay cycles into the access; addr 0x0300 answers with reg_err alone.
  int   tgt_delay = 0;
  bit   tgt_hang  = 1'b0;
  int   tgt_wait  = 0;
  logic tgt_done;

  function automatic logic [15:0] tgt_rdata(input logic [15:0] a);
    return (a == 16'h0200) ? 16'hBEEF : (a ^ 16'hA5A5);
  endfunction

  always @(posedge clk)
    tgt_wait <= (bus.reg_request && !(bus.reg_ack || bus.reg_err)) ? tgt_wait + 1 : 0;

  always_comb begin
    tgt_done      = bus.reg_request && !tgt_hang && (tgt_wait >= tgt_delay);
    bus.reg_ack   = tgt_done && (bus.reg_addr != 16'h0300);
    bus.reg_err   = tgt_done && (bus.reg_addr == 16'h0300);
    bus.reg_rdata = tgt_rdata(bus.reg_addr);
  end

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [NUM_REQ-1:0] ack;
    logic [NUM_REQ-1:0] err;
    logic [15:0]        rdata;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [15:0] exp_rdata;

  task automatic push_exp(input int idx, input bit err, input logic [15:0] rdata);
    exp_t e;
    e.ack      = '0;
    e.ack[idx] = 1'b1;
    e.err      = err ? e.ack : '0;
    e.rdata    = rdata;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (bus.req_ack !== '0) begin
      check("sb_ack_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        $display("ack cyc=%0d ack=%b err=%b rdata=%h", cyc, bus.req_ack, bus.req_err, bus.req_rdata);
        check("sb_ack",   32'(bus.req_ack),   32'(mon_e.ack));
        check("sb_err",   32'(bus.req_err),   32'(mon_e.err));
        check("sb_rdata", 32'(bus.req_rdata), 32'(mon_e.rdata));
      end
    end
  end

  task automatic wait_ack(input int max_cyc, output int at);
    bit got;
    got = 1'b0;
    at  = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (bus.req_ack !== '0) begin
        got = 1'b1;
        at  = cyc;
        break;
      end
    end
    check("ack_within_bound", 32'(got), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int at;
    int prev;
    int access_cycles;

    bus.req_request = '0;
    bus.req_write   = '0;
    bus.req_size    = '0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    exp_rdata       = 16'h0000;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_reg_request", 32'(bus.reg_request), 32'd0);
    check("rst_req_ack",     32'(bus.req_ack),     32'd0);
    check("rst_req_err",     32'(bus.req_err),     32'd0);
    check("rst_req_rdata",   32'(bus.req_rdata),   32'd0);
    check("rst_reg_addr",    32'(bus.reg_addr),    32'd0);
    check("rst_timeout",     32'(bus.timeout),     32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single read with combinational ack: reg_request at t+1, req_ack at t+2
    bus.req_addr[15:0]  = 16'h0200;
    bus.req_write[0]    = 1'b0;
    bus.req_size[0]     = 1'b1;
    bus.req_request[0]  = 1'b1;
    exp_rdata = 16'hBEEF;
    push_exp(0, 1'b0, exp_rdata);
    @(negedge clk);
    check("t1_reg_request", 32'(bus.reg_request), 32'd1);
    check("t1_reg_addr",    32'(bus.reg_addr),    32'h0200);
    check("t1_reg_size",    32'(bus.reg_size),    32'd1);
    check("t1_reg_write",   32'(bus.reg_write),   32'd0);
    check("t1_no_ack_yet",  32'(bus.req_ack),     32'd0);
    @(negedge clk);
    check("t2_req_ack",     32'(bus.req_ack),     32'b01);
    check("t2_req_rdata",   32'(bus.req_rdata),   32'hBEEF);
    bus.req_request[0] = 1'b0;
    @(negedge clk);
    check("t3_ack_pulse",   32'(bus.req_ack),     32'd0);

    // Both requesters continuously from reset: grants alternate 0,1,0,1 every 3 cycles
    rst = 1'b0;
    repeat (2) @(negedge clk);
    exp_rdata          = 16'h0000;
    bus.req_addr[15:0]  = 16'h0010;
    bus.req_addr[31:16] = 16'h0020;
    bus.req_write       = '0;
    bus.req_size        = '0;
    push_exp(0, 1'b0, tgt_rdata(16'h0010));
    push_exp(1, 1'b0, tgt_rdata(16'h0020));
    push_exp(0, 1'b0, tgt_rdata(16'h0010));
    push_exp(1, 1'b0, tgt_rdata(16'h0020));
    exp_rdata       = tgt_rdata(16'h0020);
    bus.req_request = 2'b11;
    rst = 1'b1;
    prev = 0;
    for (int n = 0; n < 4; n++) begin
      wait_ack(6, at);
      check("alt_grant", 32'(bus.req_ack), (n % 2 == 0) ? 32'b01 : 32'b10);
      if (n > 0) check("alt_spacing", 32'(at - prev), 32'd3);
      prev = at;
      if (n == 3) bus.req_request = '0;
      @(negedge clk);
      check("alt_pulse", 32'(bus.req_ack), 32'd0);
    end
    repeat (3) @(negedge clk);
    check("no_regrant", 32'(bus.reg_request), 32'd0);

    // Target error on 0x0300, then the pointer must have moved past requester 0
    bus.req_addr[15:0] = 16'h0300;
    exp_rdata = tgt_rdata(16'h0300);
    push_exp(0, 1'b1, exp_rdata);
    bus.req_request = 2'b01;
    wait_ack(6, at);
    check("err_req_err", 32'(bus.req_err), 32'b01);
    bus.req_request = '0;
    @(negedge clk);
    bus.req_addr[15:0]  = 16'h0011;
    bus.req_addr[31:16] = 16'h0021;
    push_exp(1, 1'b0, tgt_rdata(16'h0021));
    push_exp(0, 1'b0, tgt_rdata(16'h0011));
    exp_rdata = tgt_rdata(16'h0011);
    bus.req_request = 2'b11;
    wait_ack(6, at);
    check("rr_after_err", 32'(bus.req_ack), 32'b10);
    bus.req_request[1] = 1'b0;
    wait_ack(6, at);
    check("rr_second", 32'(bus.req_ack), 32'b01);
    bus.req_request[0] = 1'b0;
    @(negedge clk);

    // Delayed write: fields change mid-access but the shared port holds the latched values
    tgt_delay          = 5;
    bus.req_addr[15:0]  = 16'h0044;
    bus.req_wdata[15:0] = 16'h1357;
    bus.req_write[0]    = 1'b1;
    push_exp(0, 1'b0, exp_rdata);
    bus.req_request[0] = 1'b1;
    @(negedge clk);
    bus.req_addr[15:0]  = 16'hFFFF;
    bus.req_wdata[15:0] = 16'h0000;
    bus.req_write[0]    = 1'b0;
    check("dly_reg_write", 32'(bus.reg_write), 32'd1);
    check("dly_reg_wdata", 32'(bus.reg_wdata), 32'h1357);
    for (int i = 0; i < 5; i++) begin
      check("dly_hold_addr", 32'(bus.reg_addr), 32'h0044);
      check("dly_no_ack",    32'(bus.req_ack),  32'd0);
      @(negedge clk);
    end
    wait_ack(4, at);
    bus.req_request[0] = 1'b0;
    tgt_delay = 0;
    @(negedge clk);

    // Hung target
    tgt_hang            = 1'b1;
    bus.req_addr[31:16] = 16'h0055;
`ifdef OSD_REGARB_TIMEOUT_EN
    push_exp(1, 1'b1, 16'h0000);
    exp_rdata          = 16'h0000;
    bus.req_request[1] = 1'b1;
    access_cycles = 0;
    at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ack !== '0) begin
        at = cyc;
        break;
      end
      if (bus.reg_request) access_cycles++;
    end
    check("tmo_ack_seen",      32'(at >= 0),        32'd1);
    check("tmo_access_cycles", 32'(access_cycles),  32'(TIMEOUT));
    check("tmo_pulse",         32'(bus.timeout),    32'd1);
    check("tmo_req_err",       32'(bus.req_err),    32'b10);
    check("tmo_req_rdata",     32'(bus.req_rdata),  32'd0);
    bus.req_request[1] = 1'b0;
    @(negedge clk);
    check("tmo_pulse_end",     32'(bus.timeout),    32'd0);
    bus.req_request[1] = 1'b1;
    repeat (2) @(negedge clk);
`else
    bus.req_request[1] = 1'b1;
    repeat (1000) @(negedge clk);
    check("hang_still_access", 32'(bus.reg_request), 32'd1);
    check("hang_no_ack",       32'(bus.req_ack),     32'd0);
    check("hang_no_timeout",   32'(bus.timeout),     32'd0);
`endif

    // Reset in the middle of ACCESS abandons the access
    bus.req_request[0] = 1'b1;
    bus.req_addr[15:0] = 16'h0066;
    bus.req_write      = '0;
    check("pre_rst_access", 32'(bus.reg_request), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_reg_request", 32'(bus.reg_request), 32'd0);
    check("mid_rst_req_ack",     32'(bus.req_ack),     32'd0);
    check("mid_rst_req_err",     32'(bus.req_err),     32'd0);
    check("mid_rst_req_rdata",   32'(bus.req_rdata),   32'd0);
    check("mid_rst_reg_addr",    32'(bus.reg_addr),    32'd0);
    check("mid_rst_timeout",     32'(bus.timeout),     32'd0);
    tgt_hang = 1'b0;
    push_exp(0, 1'b0, tgt_rdata(16'h0066));
    push_exp(1, 1'b0, tgt_rdata(16'h0055));
    exp_rdata = tgt_rdata(16'h0055);
    rst = 1'b1;
    wait_ack(6, at);
    check("post_rst_first",  32'(bus.req_ack), 32'b01);
    bus.req_request[0] = 1'b0;
    wait_ack(6, at);
    check("post_rst_second", 32'(bus.req_ack), 32'b10);
    bus.req_request[1] = 1'b0;
    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("final_rdata", 32'(bus.req_rdata), 32'(exp_rdata));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
